// File: rtl/dct_butterfly_feeder_if.sv
// Signal bundle around dct_butterfly_feeder: the serial sample stream in,
// and the butterfly operand stream out to the Adder_Block.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge
// where valid and ready are both high. The sender keeps its payload stable
// while valid=1 and ready=0. Ready may be high with valid low. Neither side
// derives valid from ready combinationally.
interface dct_butterfly_feeder_if #(
    parameter int WIDTH = 16
);
    // sample input stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    // butterfly operand output stream
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             operation;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_idx;

    // vector bookkeeping
    logic [2:0]       row_count;
    logic             block_done;

    // the feeder itself: consumes samples, produces operand pairs
    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output A,
        output B,
        output operation,
        output out_valid,
        output out_idx,
        output row_count,
        output block_done
    );

    // the surroundings: sample source plus downstream adder
    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  A,
        input  B,
        input  operation,
        input  out_valid,
        input  out_idx,
        input  row_count,
        input  block_done
    );
endinterface

// File: rtl/dct_butterfly_feeder.sv
// Input-stage sequencer for the 8-point 1D DCT.
// Buffers eight Q11.4 samples, then presents the first-stage butterfly
// operand pairs (four sums, then four differences) one per handshake.
// Operands pass bit-exact; the downstream adder owns all arithmetic.
// Counts emitted vectors modulo 8 and pulses block_done on each 8x8 boundary.
module dct_butterfly_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    dct_butterfly_feeder_if.master bus,
    output logic                   o_dbg_state
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [2:0] LAST = 3'(N - 1);

    // registered state
    state_t           r_state;
    logic [2:0]       r_wr_ptr;
    logic [2:0]       r_rd_idx;
    logic [2:0]       r_row_count;
    logic [WIDTH-1:0] r_buf [N];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_block_done;

    // next-state values
    state_t           w_state_nxt;
    logic [2:0]       w_wr_ptr_nxt;
    logic [2:0]       w_rd_idx_nxt;
    logic [2:0]       w_row_count_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_op_nxt;
    logic             w_out_valid_nxt;
    logic             w_in_ready_nxt;
    logic             w_block_done_nxt;

    // handshake strobes and the operand lookup for the following pair
    logic             w_in_fire;
    logic             w_out_fire;
    logic [2:0]       w_adv_idx;
    logic [1:0]       w_adv_k;
    logic [WIDTH-1:0] w_adv_a;
    logic [WIDTH-1:0] w_adv_b;

    assign w_in_fire  = r_in_ready & bus.in_valid;
    assign w_out_fire = r_out_valid & bus.out_ready;

    // Pair i uses k = i mod 4: A = x[k], B = x[7-k]; 7-k for k in 0..3 is {1, ~k}.
    assign w_adv_idx = r_rd_idx + 3'd1;
    assign w_adv_k   = w_adv_idx[1:0];
    assign w_adv_a   = r_buf[{1'b0, w_adv_k}];
    assign w_adv_b   = r_buf[{1'b1, ~w_adv_k}];

    // Sample buffer: written only while loading; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_wr_ptr] <= bus.in_data;
        end
    end

    // Next-state and next-output decode; every output is registered from here.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_idx_nxt     = r_rd_idx;
        w_row_count_nxt  = r_row_count;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_op_nxt         = r_op;
        w_out_valid_nxt  = r_out_valid;
        w_in_ready_nxt   = r_in_ready;
        w_block_done_nxt = 1'b0;

        case (r_state)
            ST_LOAD: begin
                if (w_in_fire) begin
                    w_wr_ptr_nxt = r_wr_ptr + 3'd1;
                    if (r_wr_ptr == LAST) begin
                        // x7 is still on in_data this cycle, so pair 0 takes
                        // B from the bus rather than from the buffer.
                        w_state_nxt     = ST_EMIT;
                        w_rd_idx_nxt    = 3'd0;
                        w_a_nxt         = r_buf[0];
                        w_b_nxt         = bus.in_data;
                        w_op_nxt        = 1'b0;
                        w_out_valid_nxt = 1'b1;
                        w_in_ready_nxt  = 1'b0;
                    end
                end
            end

            ST_EMIT: begin
                if (w_out_fire) begin
                    if (r_rd_idx == LAST) begin
                        w_state_nxt      = ST_LOAD;
                        w_rd_idx_nxt     = 3'd0;
                        w_row_count_nxt  = r_row_count + 3'd1;
                        w_block_done_nxt = (r_row_count == 3'd7);
                        w_a_nxt          = '0;
                        w_b_nxt          = '0;
                        w_op_nxt         = 1'b0;
                        w_out_valid_nxt  = 1'b0;
                        w_in_ready_nxt   = 1'b1;
                    end else begin
                        // upper half of the index range requests differences
                        w_rd_idx_nxt = w_adv_idx;
                        w_a_nxt      = w_adv_a;
                        w_b_nxt      = w_adv_b;
                        w_op_nxt     = w_adv_idx[2];
                    end
                end
            end

            default: begin
                w_state_nxt     = ST_LOAD;
                w_wr_ptr_nxt    = 3'd0;
                w_rd_idx_nxt    = 3'd0;
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset drops any
    // partial vector or pending pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_wr_ptr     <= 3'd0;
            r_rd_idx     <= 3'd0;
            r_row_count  <= 3'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 1'b0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_block_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_idx     <= w_rd_idx_nxt;
            r_row_count  <= w_row_count_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_op         <= w_op_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_block_done <= w_block_done_nxt;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.operation  = r_op;
    assign bus.out_idx    = r_rd_idx;
    assign bus.row_count  = r_row_count;
    assign bus.block_done = r_block_done;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dct_butterfly_feeder.sv
// Bench for dct_butterfly_feeder: random and directed vectors checked
// against a pair-list model of the butterfly input stage.
module tb_dct_butterfly_feeder;

    localparam int WIDTH = 16;
    localparam int W     = 3 + 1 + 2 * WIDTH;  // {idx, op, A, B}

    typedef logic [WIDTH-1:0] vec_t [8];
    typedef struct packed {
        logic             v;
        logic             r;
        logic             ir;
        logic [2:0]       idx;
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int bd_count    = 0;
    int bd_cyc      = -1;
    int last_hs_cyc = -1;

    vec_t         vec;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    obs_t         trace_q[$];

    dct_butterfly_feeder_if #(.WIDTH(WIDTH)) bus ();

    dct_butterfly_feeder #(.WIDTH(WIDTH), .N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.block_done === 1'b1) begin
            bd_count++;
            bd_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Pair j: k = j mod 4, A = x[k], B = x[7-k], difference when j >= 4.
    function automatic void model_vector(input vec_t v);
        for (int j = 0; j < 8; j++) begin
            int k;
            k = j % 4;
            exp_q.push_back({3'(j), 1'(j / 4), v[k], v[7 - k]});
        end
    endfunction

    task automatic rand_vec();
        for (int i = 0; i < 8; i++) vec[i] = WIDTH'($urandom);
    endtask

    // ---------------- drivers ----------------
    task automatic send_vector(input int count, input bit gappy, output int cycles);
        int   n;
        bit   tog;
        logic acc;
        n      = 0;
        tog    = 1'b1;
        cycles = 0;
        while (n < count && cycles < 200) begin
            bus.in_valid = gappy ? tog : 1'b1;
            bus.in_data  = bus.in_valid ? vec[n] : WIDTH'($urandom);
            acc          = bus.in_valid && bus.in_ready;
            tog          = ~tog;
            step();
            cycles++;
            if (acc) n++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = WIDTH'($urandom);
        checks++;
        if (n != count) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d samples, required %0d", n, count);
        end
    endtask

    // Drives out_ready, records every cycle in trace_q and every handshake in got_q.
    task automatic collect(input int stall_idx, input int stall_len, input bit rand_rdy, input int max_hs);
        int   hs;
        int   guard;
        int   left;
        logic rdy;
        obs_t o;
        hs    = 0;
        guard = 0;
        left  = stall_len;
        trace_q.delete();
        got_q.delete();
        while (hs < max_hs && guard < 300) begin
            rdy = 1'b1;
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
            else if (bus.out_valid && int'(bus.out_idx) == stall_idx && left > 0) begin
                rdy = 1'b0;
                left--;
            end
            bus.out_ready = rdy;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = WIDTH'($urandom);
            o.v   = bus.out_valid;
            o.r   = rdy;
            o.ir  = bus.in_ready;
            o.idx = bus.out_idx;
            o.op  = bus.operation;
            o.a   = bus.A;
            o.b   = bus.B;
            trace_q.push_back(o);
            if (bus.out_valid && rdy) begin
                got_q.push_back({bus.out_idx, bus.operation, bus.A, bus.B});
                hs++;
                last_hs_cyc = cyc;
            end
            step();
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (hs != max_hs) begin
            errors++;
            $display("FAIL collect_timeout: saw %0d handshakes, required %0d", hs, max_hs);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
        end
        checks++;
        if ({bus.A, bus.B, bus.operation, bus.out_idx} !== '0) begin
            errors++;
            $display("FAIL reset_operands: A=%h B=%h op=%b idx=%0d required all 0", bus.A, bus.B, bus.operation, bus.out_idx);
        end
        checks++;
        if ({bus.row_count, bus.block_done, dbg_state} !== 5'b0) begin
            errors++;
            $display("FAIL reset_count: row_count=%0d block_done=%b state=%b required 0", bus.row_count, bus.block_done, dbg_state);
        end
    endtask

    task automatic test_directed();
        int cyc_n;
        int n_busy;
        vec[0] = 16'h0100; vec[1] = 16'h0010; vec[2] = 16'h0020; vec[3] = 16'h0030;
        vec[4] = 16'h0040; vec[5] = 16'h0050; vec[6] = 16'h0060; vec[7] = 16'h0140;
        model_vector(vec);
        send_vector(8, 1'b0, cyc_n);
        checks++;
        if ({bus.out_valid, bus.A, bus.B, bus.operation, bus.out_idx} !== {1'b1, 16'h0100, 16'h0140, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL directed_latency: v=%b A=%h B=%h op=%b idx=%0d required 1/0100/0140/0/0",
                     bus.out_valid, bus.A, bus.B, bus.operation, bus.out_idx);
        end
        collect(-1, 0, 1'b0, 8);
        n_busy = 0;
        foreach (trace_q[i]) if (trace_q[i].v && !trace_q[i].ir) n_busy++;
        checks++;
        if (n_busy != 8 || trace_q.size() != 8) begin
            errors++;
            $display("FAIL directed_span: %0d busy cycles of %0d traced, required 8 of 8", n_busy, trace_q.size());
        end
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.row_count} !== {1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL directed_return: in_ready=%b out_valid=%b row_count=%0d required 1/0/1",
                     bus.in_ready, bus.out_valid, bus.row_count);
        end
        checks++;
        if (got_q[3] !== {3'd3, 1'b0, 16'h0030, 16'h0040}) begin
            errors++;
            $display("FAIL directed_pair3: got %h required %h", got_q[3], {3'd3, 1'b0, 16'h0030, 16'h0040});
        end
        checks++;
        if (got_q[4] !== {3'd4, 1'b1, 16'h0100, 16'h0140}) begin
            errors++;
            $display("FAIL directed_pair4: got %h required %h", got_q[4], {3'd4, 1'b1, 16'h0100, 16'h0140});
        end
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL directed_scoreboard: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_back_pressure();
        int cyc_n;
        int n_stall;
        int n_bubble;
        model_vector(vec);
        send_vector(8, 1'b0, cyc_n);
        collect(2, 5, 1'b0, 8);
        n_stall  = 0;
        n_bubble = 0;
        foreach (trace_q[i]) begin
            if (!trace_q[i].v) n_bubble++;
            if (trace_q[i].v && !trace_q[i].r) begin
                n_stall++;
                checks++;
                if ({trace_q[i].idx, trace_q[i].op, trace_q[i].a, trace_q[i].b} !== {3'd2, 1'b0, 16'h0020, 16'h0050}) begin
                    errors++;
                    $display("FAIL bp_hold: idx=%0d op=%b A=%h B=%h required 2/0/0020/0050",
                             trace_q[i].idx, trace_q[i].op, trace_q[i].a, trace_q[i].b);
                end
            end
        end
        checks++;
        if (n_stall != 5 || n_bubble != 0 || trace_q.size() != 13) begin
            errors++;
            $display("FAIL bp_span: stalls=%0d bubbles=%0d cycles=%0d required 5/0/13", n_stall, n_bubble, trace_q.size());
        end
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count: %0d handshakes, required 8", got_q.size());
        end
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL bp_scoreboard: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_negative();
        int cyc_n;
        rand_vec();
        vec[0] = 16'hFEC0;
        vec[7] = 16'h0100;
        model_vector(vec);
        send_vector(8, 1'b0, cyc_n);
        collect(-1, 0, 1'b0, 8);
        checks++;
        if (got_q[0] !== {3'd0, 1'b0, 16'hFEC0, 16'h0100}) begin
            errors++;
            $display("FAIL neg_pair0: got %h required %h", got_q[0], {3'd0, 1'b0, 16'hFEC0, 16'h0100});
        end
        checks++;
        if (got_q[4] !== {3'd4, 1'b1, 16'hFEC0, 16'h0100}) begin
            errors++;
            $display("FAIL neg_pair4: got %h required %h", got_q[4], {3'd4, 1'b1, 16'hFEC0, 16'h0100});
        end
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL neg_scoreboard: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_gappy();
        int cyc_n;
        rand_vec();
        model_vector(vec);
        send_vector(8, 1'b1, cyc_n);
        checks++;
        if (cyc_n != 15) begin
            errors++;
            $display("FAIL gappy_cycles: load took %0d cycles, required 15", cyc_n);
        end
        checks++;
        if ({bus.out_valid, bus.in_ready, dbg_state} !== 3'b101) begin
            errors++;
            $display("FAIL gappy_emit: out_valid/in_ready/state=%b required 101", {bus.out_valid, bus.in_ready, dbg_state});
        end
        collect(-1, 0, 1'b0, 8);
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL gappy_scoreboard: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_row_count();
        int cyc_n;
        do_reset();
        bd_count = 0;
        bd_cyc   = -1;
        for (int v = 0; v < 8; v++) begin
            rand_vec();
            model_vector(vec);
            send_vector(8, 1'b0, cyc_n);
            collect(-1, 0, 1'b0, 8);
            checks++;
            if (int'(bus.row_count) != (v + 1) % 8) begin
                errors++;
                $display("FAIL row_count_step: row_count=%0d required %0d", bus.row_count, (v + 1) % 8);
            end
            checks++;
            if (bus.block_done !== (v == 7)) begin
                errors++;
                $display("FAIL row_done_level: vector %0d block_done=%b required %b", v, bus.block_done, (v == 7));
            end
            while (exp_q.size() > 0) begin
                logic [W-1:0] e;
                logic [W-1:0] g;
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : '0;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL row_scoreboard: vector %0d got %h required %h", v, g, e);
                end
            end
        end
        step();
        checks++;
        if (bus.block_done !== 1'b0) begin
            errors++;
            $display("FAIL row_done_width: block_done=%b a second cycle, required 0", bus.block_done);
        end
        checks++;
        if (bd_count != 1 || bd_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL row_done_pulse: pulses=%0d at cycle %0d, required 1 at cycle %0d", bd_count, bd_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        int cyc_n;
        rand_vec();
        send_vector(8, 1'b0, cyc_n);
        collect(-1, 0, 1'b0, 5);
        checks++;
        if (bus.out_idx !== 3'd5) begin
            errors++;
            $display("FAIL rst_mid_setup: idx=%0d required 5", bus.out_idx);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.row_count, bus.A, bus.B, bus.operation, bus.out_idx, bus.block_done}
            !== {1'b0, 1'b1, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_outputs: v=%b ir=%b rc=%0d A=%h B=%h op=%b idx=%0d bd=%b required all 0 except in_ready",
                     bus.out_valid, bus.in_ready, bus.row_count, bus.A, bus.B, bus.operation, bus.out_idx, bus.block_done);
        end
        // partial load abandoned by reset
        rand_vec();
        send_vector(3, 1'b0, cyc_n);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rand_vec();
        model_vector(vec);
        send_vector(8, 1'b0, cyc_n);
        collect(-1, 0, 1'b0, 8);
        checks++;
        if (bus.row_count !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid_count: row_count=%0d required 1", bus.row_count);
        end
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rst_mid_scoreboard: got %h required %h", g, e);
            end
        end
    endtask

    task automatic test_random();
        int cyc_n;
        for (int v = 0; v < 6; v++) begin
            rand_vec();
            model_vector(vec);
            send_vector(8, 1'($urandom_range(0, 1)), cyc_n);
            collect(-1, 0, 1'b1, 8);
            for (int i = 1; i < trace_q.size(); i++) begin
                if (trace_q[i-1].v && !trace_q[i-1].r) begin
                    checks++;
                    if ({trace_q[i].v, trace_q[i].idx, trace_q[i].op, trace_q[i].a, trace_q[i].b} !==
                        {1'b1, trace_q[i-1].idx, trace_q[i-1].op, trace_q[i-1].a, trace_q[i-1].b}) begin
                        errors++;
                        $display("FAIL rand_hold: idx=%0d A=%h B=%h changed from idx=%0d A=%h B=%h while stalled",
                                 trace_q[i].idx, trace_q[i].a, trace_q[i].b, trace_q[i-1].idx, trace_q[i-1].a, trace_q[i-1].b);
                    end
                end
            end
            while (exp_q.size() > 0) begin
                logic [W-1:0] e;
                logic [W-1:0] g;
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : '0;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL rand_scoreboard: vector %0d got %h required %h", v, g, e);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_pressure();
        test_negative();
        test_gappy();
        test_row_count();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout: run exceeded 500000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
